// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory port: fetch (0) vs load/store (1).
// One transaction at a time: accept in IDLE, present in ISSUE, wait in WAIT_RESP.
module mem_port_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_we,
    output logic              req1_ready,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid0,
    output logic              resp_valid1,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              sel,
    output logic              busy
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t             state, state_d;
    logic               last_grant, last_grant_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               sel_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic               mem_we_d;
    logic               mem_valid_d;
    logic               busy_d;
    logic               resp_valid0_d, resp_valid1_d;
    logic [DATA_W-1:0]  resp_rdata_d;
    logic               resp_err_d;
    logic               winner;

    // State and all registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cnt         <= '0;
            sel         <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_valid   <= 1'b0;
            busy        <= 1'b0;
            resp_valid0 <= 1'b0;
            resp_valid1 <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            state       <= state_d;
            last_grant  <= last_grant_d;
            cnt         <= cnt_d;
            sel         <= sel_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_we      <= mem_we_d;
            mem_valid   <= mem_valid_d;
            busy        <= busy_d;
            resp_valid0 <= resp_valid0_d;
            resp_valid1 <= resp_valid1_d;
            resp_rdata  <= resp_rdata_d;
            resp_err    <= resp_err_d;
        end
    end

    // Next-state, grant selection and response generation.
    always_comb begin
        state_d       = state;
        last_grant_d  = last_grant;
        cnt_d         = cnt;
        sel_d         = sel;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        mem_we_d      = mem_we;
        mem_valid_d   = mem_valid;
        busy_d        = busy;
        resp_valid0_d = 1'b0;
        resp_valid1_d = 1'b0;
        resp_rdata_d  = '0;
        resp_err_d    = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        // On a tie the requester not served last wins.
        winner        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready  = ~winner;
                    req1_ready  = winner;
                    sel_d       = winner;
                    mem_addr_d  = winner ? req1_addr : req0_addr;
                    mem_wdata_d = winner ? req1_wdata : '0;
                    mem_we_d    = winner ? req1_we : 1'b0;
                    mem_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                cnt_d = cnt + CNT_W'(1);
                // A response arriving on the expiry cycle takes priority over the error.
                if (mem_resp_valid || (cnt == CNT_W'(TIMEOUT - 1))) begin
                    resp_valid0_d = ~sel;
                    resp_valid1_d = sel;
                    resp_rdata_d  = mem_resp_valid ? mem_rdata : '0;
                    resp_err_d    = ~mem_resp_valid;
                    last_grant_d  = sel;
                    busy_d        = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-level bench for mem_port_arbiter: the bench plays memory and
// predicts grant order, latched fields and response timing from the arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req0_ready, req1_ready;
    logic          mem_valid, mem_ready, mem_we, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, resp_rdata;
    logic          resp_valid0, resp_valid1, resp_err, sel, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: who was served last, and the mux select after the last accept.
    bit m_last = 1'b1;
    bit m_sel  = 1'b0;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_we(req1_we), .req1_ready(req1_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration round starting in an IDLE cycle. resp_dly is the WAIT_RESP
    // cycle index on which memory answers; anything outside 0..TO-1 means no answer.
    task automatic run_txn(input bit v0, input bit v1, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [31:0] wd, input bit we,
                           input int rdy_dly, input int resp_dly,
                           input logic [31:0] rd, input bit late);
        bit w, to;
        logic [31:0] ea, ewd;
        bit ewe;
        int last;
        req0_valid = v0; req0_addr = a0;
        req1_valid = v1; req1_addr = a1; req1_wdata = wd; req1_we = we;
        #1;
        if (!v0 && !v1) begin
            check("idle_ready0", req0_ready, 0);
            check("idle_ready1", req1_ready, 0);
            tick();
            check("idle_busy", busy, 0);
            check("idle_sel_hold", sel, m_sel);
            return;
        end
        w   = (v0 && v1) ? !m_last : v1;
        ea  = w ? a1 : a0;
        ewd = w ? wd : 32'h0;
        ewe = w ? we : 1'b0;
        check("accept_ready0", req0_ready, !w);
        check("accept_ready1", req1_ready, w);
        tick();
        m_sel = w;
        // Scramble request inputs to prove the fields were latched.
        req0_addr = $urandom; req1_addr = $urandom; req1_wdata = $urandom; req1_we = $urandom_range(0, 1);
        for (int i = 0; i <= rdy_dly; i++) begin
            mem_ready      = (i == rdy_dly);
            mem_resp_valid = (i < rdy_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata      = $urandom;
            #1;
            check("issue_valid", mem_valid, 1);
            check("issue_addr", mem_addr, ea);
            check("issue_wdata", mem_wdata, ewd);
            check("issue_we", mem_we, ewe);
            check("issue_sel", sel, w);
            check("issue_busy", busy, 1);
            check("issue_ready", {req0_ready, req1_ready}, 0);
            check("issue_noresp", {resp_valid0, resp_valid1}, 0);
            tick();
        end
        mem_ready      = 1'b0;
        mem_resp_valid = 1'b0;
        to   = !(resp_dly >= 0 && resp_dly < int'(TO));
        last = to ? int'(TO) - 1 : resp_dly;
        for (int k = 0; k <= last; k++) begin
            mem_resp_valid = (k == resp_dly);
            mem_rdata      = (k == resp_dly) ? rd : $urandom;
            #1;
            check("wait_memvalid", mem_valid, 0);
            check("wait_busy", busy, 1);
            check("wait_noresp", {resp_valid0, resp_valid1, resp_err}, 0);
            check("wait_rdata_zero", resp_rdata, 0);
            tick();
        end
        mem_resp_valid = 1'b0;
        check("resp_valid0", resp_valid0, !w);
        check("resp_valid1", resp_valid1, w);
        check("resp_rdata", resp_rdata, to ? 32'h0 : rd);
        check("resp_err", resp_err, to);
        check("resp_busy", busy, 0);
        check("resp_sel", sel, w);
        m_last = w;
        if (late) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            tick();
            for (int j = 0; j < 4; j++) begin
                mem_resp_valid = (j == 1);
                mem_rdata      = $urandom;
                #1;
                check("late_ignored", {resp_valid0, resp_valid1, resp_err, busy}, 0);
                tick();
            end
            mem_resp_valid = 1'b0;
        end
    endtask

    // Accept a tied request, then assert reset asynchronously in ISSUE (in_wait=0)
    // or in WAIT_RESP (in_wait=1); nothing may be delivered.
    task automatic reset_mid(input bit in_wait);
        req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 32'h40; req1_addr = 32'h80;
        #1;
        tick();
        if (in_wait) begin
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            tick();
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_memvalid", mem_valid, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_sel", sel, 0);
        check("rst_async_resp", {resp_valid0, resp_valid1, resp_err}, 0);
        check("rst_async_addr", mem_addr, 0);
        tick();
        check("rst_hold_resp", {resp_valid0, resp_valid1, busy}, 0);
        rst_n  = 1'b1;
        m_last = 1'b1;
        m_sel  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req1_we = 1'b0;
        req0_addr = '0; req1_addr = '0; req1_wdata = '0;
        mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_memvalid", mem_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_sel", sel, 0);
        check("reset_resp", {resp_valid0, resp_valid1, resp_err}, 0);
        check("reset_rdata", resp_rdata, 0);
        check("reset_fields", {mem_addr[15:0], mem_wdata[14:0], mem_we}, 0);
        rst_n = 1'b1;
        tick();

        // Single fetch with minimum latency.
        run_txn(1, 0, 32'h100, 32'h0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 0);
        // Both requesting: grants alternate.
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 32'h0, 32'h200, 32'h55, 1, 0, 1, $urandom, 0);
        // Memory stalls in ISSUE for 5 cycles.
        run_txn(1, 0, 32'h300, 32'h0, 32'h0, 0, 5, 2, 32'hA5A5_0001, 0);
        // No response: timeout, then a late response is ignored.
        run_txn(0, 1, 32'h0, 32'h400, 32'h77, 0, 0, -1, 32'h0, 1);
        // Response exactly on the expiry cycle wins.
        run_txn(1, 0, 32'h500, 32'h0, 32'h0, 0, 0, int'(TO) - 1, 32'h1234, 0);
        // Asynchronous reset mid-transaction; a tie afterwards goes to fetch.
        reset_mid(1);
        run_txn(1, 1, 32'h600, 32'h700, 32'h9, 1, 0, 0, 32'hCAFE, 0);
        reset_mid(0);
        run_txn(1, 1, 32'h610, 32'h710, 32'h8, 0, 1, 3, 32'hBEEF, 0);

        // Randomized rounds.
        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    $urandom_range(0, 20), $urandom, 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester, round-robin arbiter for the single shared memory port in the RISC-V core.
- Requester 0 is instruction fetch. Requester 1 is load/store.
- Drives the select of the 2-to-1 address/data mux in front of memory and sequences one transaction at a time: accept, issue, wait for response.
- Routes each response back to its originator and bounds the wait with a timeout.

Parameters:
DATA_W, 32, data width of wdata/rdata
ADDR_W, 32, address width
TIMEOUT, 16, max cycles in WAIT_RESP before an error response (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  fetch request
req0_addr  input  ADDR_W  fetch address
req0_ready  output  1  fetch request accepted this cycle
req1_valid  input  1  load/store request
req1_addr  input  ADDR_W  load/store address
req1_wdata  input  DATA_W  store data
req1_we  input  1  1=store, 0=load
req1_ready  output  1  load/store request accepted this cycle
mem_valid  output  1  request to memory
mem_ready  input  1  memory accepts request
mem_addr  output  ADDR_W  latched address
mem_wdata  output  DATA_W  latched store data (0 for fetch)
mem_we  output  1  latched write enable (0 for fetch)
mem_resp_valid  input  1  memory response
mem_rdata  input  DATA_W  memory read data
resp_valid0  output  1  response to fetch, one-cycle pulse
resp_valid1  output  1  response to load/store, one-cycle pulse
resp_rdata  output  DATA_W  response data, shared by both requesters
resp_err  output  1  response is a timeout error
sel  output  1  mux select = current grant (0 fetch, 1 load/store)
busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- One clock domain: clk. Reset rst_n is asynchronous, active-low, and takes effect immediately regardless of clk.
- Reset values:
  - state=IDLE, sel=0, last_grant=1 (requester 0 wins the first tie), timeout counter=0.
  - All latched addr/wdata/we registers=0.
  - mem_valid, resp_valid0/1, resp_err, busy = 0; resp_rdata=0.
- Reset mid-transaction: everything aborts to the reset values. No response is delivered. mem_valid drops asynchronously.
- State IDLE:
  - reqX_ready is combinational: asserted only for the winner, only in IDLE.
  - Winner: if only one reqX_valid, that one. If both, the one != last_grant.
  - Handshake = reqX_valid & reqX_ready. On handshake: latch addr/wdata/we and set sel=winner.
  - Requester 0 latches wdata=0 and we=0.
  - On handshake, go to ISSUE. With no request, remain in IDLE and hold sel.
- State ISSUE:
  - mem_valid=1 with the latched fields; fields stay stable until mem_ready.
  - On mem_ready, go to WAIT_RESP and clear the counter.
  - No timeout in ISSUE: wait indefinitely for mem_ready.
- State WAIT_RESP:
  - Counter increments each cycle.
  - If mem_resp_valid: pulse resp_validSEL for one cycle (registered, next cycle) with resp_rdata=mem_rdata and resp_err=0. Set last_grant=sel and go to IDLE.
  - Else if counter reaches TIMEOUT-1: pulse resp_validSEL with resp_rdata=0 and resp_err=1. Set last_grant=sel and go to IDLE.
  - If mem_resp_valid coincides with expiry, the response wins (err=0).
- mem_resp_valid in IDLE or ISSUE, including late responses after a timeout, is ignored.
- Only one of resp_valid0/1 is high at a time. Both requesters share resp_rdata/resp_err, which are meaningful only during a pulse and 0 otherwise.
- Latency: accept cycle N, mem_valid from N+1; with mem_ready at N+1 and mem_resp_valid at N+2, resp_valid at N+3.
- The next accept is possible in the same cycle as the response pulse, because state=IDLE then.
- sel changes only on an IDLE handshake, so the mux is never switched mid-transaction.

Test Plan:
1. Reset, then req0_valid=1, addr=0x100; memory ready immediately, resp 1 cycle later with rdata=0xDEADBEEF -> req0_ready high in accept cycle; mem_addr=0x100, mem_we=0; resp_valid0 one cycle with rdata 0xDEADBEEF; sel=0.
2. Both requesting continuously (req0 addr 0x0, req1 store 0x200/0x55) -> grants alternate 0,1,0,1; for req1 transactions mem_we=1, mem_wdata=0x55 and sel=1; no requester served twice in a row.
3. Hold mem_ready=0 for 5 cycles in ISSUE -> mem_valid and fields stable for all 5 cycles; no timeout; busy=1; both readys 0.
4. No mem_resp_valid after accept (TIMEOUT=16) -> 16 cycles in WAIT_RESP, then resp_validSEL with resp_err=1, rdata=0; a late mem_resp_valid 3 cycles later produces no output.
5. mem_resp_valid on exactly the timeout-expiry cycle with rdata=0x1234 -> resp_err=0, rdata=0x1234.
6. Assert rst_n=0 asynchronously mid-WAIT_RESP -> immediate mem_valid=0, busy=0, no resp pulse; after release, a tie grants requester 0 first.
